// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris VGA renderer: board geometry,
// 640x480@60 VGA timing and the pixel colour payload.
package tetris_pkg;

    localparam int unsigned BOARD_W     = 10;
    localparam int unsigned BOARD_H     = 20;
    localparam int unsigned BOARD_CELLS = BOARD_W * BOARD_H;

    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_FP_END     = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 492;
    localparam int unsigned V_TOTAL      = 525;

    localparam int unsigned HCNT_W     = 10;
    localparam int unsigned VCNT_W     = 10;
    localparam int unsigned COL_W      = $clog2(BOARD_W);
    localparam int unsigned ROW_W      = $clog2(BOARD_H);
    localparam int unsigned CELL_IDX_W = $clog2(BOARD_CELLS);
    localparam int unsigned FRAME_PX   = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t RGB_FILLED = '{r: 8'h00, g: 8'hff, b: 8'hff};
    localparam rgb_t RGB_EMPTY  = '{r: 8'h20, g: 8'h20, b: 8'h20};
    localparam rgb_t RGB_GRID   = '{r: 8'h40, g: 8'h40, b: 8'h40};
    localparam rgb_t RGB_FRAME  = '{r: 8'h80, g: 8'h80, b: 8'h80};

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider and 800x525 raster counters with raw (unregistered)
// sync and active-area flags decoded from the current counter values.
module vga_timing
    import tetris_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    output logic              pix_en,
    output logic [HCNT_W-1:0] hcount,
    output logic [VCNT_W-1:0] vcount,
    output logic              hsync_n_c,
    output logic              vsync_n_c,
    output logic              active_c
);

    logic h_last;
    logic v_last;

    assign h_last = (hcount == HCNT_W'(H_TOTAL - 1));
    assign v_last = (vcount == VCNT_W'(V_TOTAL - 1));

    // pix_en halves clk; the raster only moves on pix_en cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_en <= 1'b0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (h_last) begin
                    hcount <= '0;
                    vcount <= v_last ? '0 : vcount + VCNT_W'(1);
                end else begin
                    hcount <= hcount + HCNT_W'(1);
                end
            end
        end
    end

    assign hsync_n_c = !((hcount >= HCNT_W'(H_FP_END)) && (hcount < HCNT_W'(H_SYNC_END)));
    assign vsync_n_c = !((vcount >= VCNT_W'(V_SYNC_START)) && (vcount < VCNT_W'(V_SYNC_END)));
    assign active_c  = (hcount < HCNT_W'(H_ACTIVE)) && (vcount < VCNT_W'(V_ACTIVE));

endmodule

// File: rtl/tetris_vga_renderer.sv
// Renders a 10x20 Tetris board as a VGA 640x480 image; the board is latched
// once per frame during vertical blanking so a frame never mixes two boards.
module tetris_vga_renderer
    import tetris_pkg::*;
#(
    parameter int unsigned CELL_PX  = 16,
    parameter int unsigned BOARD_X0 = 240,
    parameter int unsigned BOARD_Y0 = 80
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [BOARD_CELLS-1:0] board,
    output logic                   vga_clk,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic [7:0]             vga_r,
    output logic [7:0]             vga_g,
    output logic [7:0]             vga_b
);

    localparam int unsigned CELL_SHIFT = $clog2(CELL_PX);
    localparam int unsigned BOARD_X1   = BOARD_X0 + BOARD_W * CELL_PX;
    localparam int unsigned BOARD_Y1   = BOARD_Y0 + BOARD_H * CELL_PX;

    logic              pix_en;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hsync_n_c;
    logic              vsync_n_c;
    logic              active_c;

    logic [BOARD_CELLS-1:0] shadow;
    logic                   in_board_c;
    logic                   in_frame_c;
    logic                   edge_c;
    logic                   filled_c;
    logic [COL_W-1:0]       col_c;
    logic [ROW_W-1:0]       row_c;
    logic [CELL_IDX_W-1:0]  cell_idx_c;
    rgb_t                   pix_c;
    rgb_t                   pix_q;

    vga_timing u_timing (
        .clk       (clk),
        .resetn    (resetn),
        .pix_en    (pix_en),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync_n_c (hsync_n_c),
        .vsync_n_c (vsync_n_c),
        .active_c  (active_c)
    );

    // Region decode and cell address; index forced to 0 outside the board
    always_comb begin
        in_board_c = (32'(hcount) >= BOARD_X0) && (32'(hcount) < BOARD_X1) &&
                     (32'(vcount) >= BOARD_Y0) && (32'(vcount) < BOARD_Y1);
        in_frame_c = !in_board_c &&
                     (32'(hcount) + FRAME_PX >= BOARD_X0) && (32'(hcount) < BOARD_X1 + FRAME_PX) &&
                     (32'(vcount) + FRAME_PX >= BOARD_Y0) && (32'(vcount) < BOARD_Y1 + FRAME_PX);
        col_c  = COL_W'((hcount - HCNT_W'(BOARD_X0)) >> CELL_SHIFT);
        row_c  = ROW_W'((vcount - VCNT_W'(BOARD_Y0)) >> CELL_SHIFT);
        edge_c = (((hcount - HCNT_W'(BOARD_X0)) & HCNT_W'(CELL_PX - 1)) == HCNT_W'(CELL_PX - 1)) ||
                 (((vcount - VCNT_W'(BOARD_Y0)) & VCNT_W'(CELL_PX - 1)) == VCNT_W'(CELL_PX - 1));
        cell_idx_c = '0;
        if (in_board_c) begin
            cell_idx_c = CELL_IDX_W'(row_c) * CELL_IDX_W'(BOARD_W) + CELL_IDX_W'(col_c);
        end
        filled_c = shadow[cell_idx_c];
    end

    // Colour priority: grid line, cell fill, surrounding frame, background
    always_comb begin
        pix_c = RGB_BLACK;
        if (active_c) begin
            if (in_board_c) begin
                if (edge_c) begin
                    pix_c = RGB_GRID;
                end else if (filled_c) begin
                    pix_c = RGB_FILLED;
                end else begin
                    pix_c = RGB_EMPTY;
                end
            end else if (in_frame_c) begin
                pix_c = RGB_FRAME;
            end
        end
    end

    // Sync, blank and colour all registered on the same pix_en edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            pix_q       <= RGB_BLACK;
            shadow      <= '0;
        end else if (pix_en) begin
            vga_hs      <= hsync_n_c;
            vga_vs      <= vsync_n_c;
            vga_blank_n <= active_c;
            pix_q       <= pix_c;
            if ((hcount == '0) && (vcount == VCNT_W'(V_ACTIVE))) begin
                shadow <= board;
            end
        end
    end

    assign vga_clk = pix_en;
    assign vga_r   = pix_q.r;
    assign vga_g   = pix_q.g;
    assign vga_b   = pix_q.b;

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Scoreboard bench: a producer predicts every pixel from a frame-level model
// of the board; a monitor pops and compares each pixel the DUT presents.
module tb_tetris_vga_renderer;

    localparam int CELL = 16;
    localparam int X0   = 240;
    localparam int Y0   = 80;

    logic         clk;
    logic         resetn;
    logic [199:0] board;
    logic         vga_clk, vga_hs, vga_vs, vga_blank_n;
    logic [7:0]   vga_r, vga_g, vga_b;

    int checks = 0;
    int failures = 0;
    int pix_checks = 0;
    int point_hits = 0;
    int unsigned cyc = 0;
    bit aborted = 0;

    typedef struct {
        int          h;
        int          v;
        int          frame;
        logic [26:0] exp;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          f;
        int          h;
        int          v;
        logic [23:0] rgb;
    } pt_t;
    pt_t pts [9] = '{
        '{0, 248,  88, 24'h202020},
        '{1, 248,  88, 24'h00ffff},
        '{1, 248, 104, 24'h00ffff},
        '{1, 360, 104, 24'h202020},
        '{1, 255,  80, 24'h404040},
        '{1, 238, 200, 24'h808080},
        '{1,  10,  10, 24'h000000},
        '{3, 248, 300, 24'h00ffff},
        '{4, 248, 250, 24'h202020}
    };

    tetris_vga_renderer #(.CELL_PX(16), .BOARD_X0(240), .BOARD_Y0(80)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .board       (board),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference picture: {hs, vs, blank_n, r, g, b} for pixel (h, v)
    function automatic logic [26:0] model_px(int h, int v, logic [199:0] sh);
        logic hs, vs, bl;
        logic [23:0] c;
        int col, row;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 490 && v < 492);
        bl = (h < 640) && (v < 480);
        c  = 24'h000000;
        if (bl) begin
            if (h >= X0 && h < X0 + 10 * CELL && v >= Y0 && v < Y0 + 20 * CELL) begin
                col = (h - X0) / CELL;
                row = (v - Y0) / CELL;
                if ((h - X0) % CELL == CELL - 1 || (v - Y0) % CELL == CELL - 1) c = 24'h404040;
                else if (sh[row * 10 + col]) c = 24'h00ffff;
                else c = 24'h202020;
            end else if (h >= X0 - 4 && h < X0 + 10 * CELL + 4 && v >= Y0 - 4 && v < Y0 + 20 * CELL + 4) begin
                c = 24'h808080;
            end
        end
        return {hs, vs, bl, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Producer: predicts the pixel the DUT will emit on the next clk edge
    int ph = 0, pv = 0, pframe = 0;
    logic [199:0] sh_model = '0;
    always @(negedge clk) begin
        if (!resetn) begin
            if (ph != 0 || pv != 0) pframe = 100;
            ph = 0;
            pv = 0;
            sh_model = '0;
        end else if (vga_clk) begin
            exp_q.push_back('{ph, pv, pframe, model_px(ph, pv, sh_model)});
            if (ph == 0 && pv == 480) sh_model = board;
            if (ph == 799) begin
                ph = 0;
                if (pv == 524) begin
                    pv = 0;
                    pframe++;
                end else begin
                    pv++;
                end
            end else begin
                ph++;
            end
        end
    end

    // Monitor: a new pixel is on the outputs whenever vga_clk has just fallen
    always @(negedge clk) begin
        exp_t e;
        logic [26:0] act;
        if (!vga_clk && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
            checks++;
            pix_checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL pixel f%0d (%0d,%0d): got %h expected %h", e.frame, e.h, e.v, act, e.exp);
            end
            for (int i = 0; i < 9; i++) begin
                if (pts[i].f == e.frame && pts[i].h == e.h && pts[i].v == e.v) begin
                    point_hits++;
                    checks++;
                    if (act[23:0] !== pts[i].rgb) begin
                        failures++;
                        $display("FAIL point f%0d (%0d,%0d): got %h expected %h", e.frame, e.h, e.v, act[23:0], pts[i].rgb);
                    end
                end
            end
        end
    end

    // Sync edge recorder, cleared while in reset
    int unsigned hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    always @(negedge clk) begin
        if (!resetn) begin
            hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
        end else begin
            if (hs_prev && !vga_hs) hs_fall.push_back(cyc);
            if (!hs_prev && vga_hs) hs_rise.push_back(cyc);
            if (vs_prev && !vga_vs) vs_fall.push_back(cyc);
            if (!vs_prev && vga_vs) vs_rise.push_back(cyc);
        end
        hs_prev = vga_hs;
        vs_prev = vga_vs;
    end

    task automatic wait_until(input int f, input int v);
        int n = 0;
        if (aborted) return;
        while (!(pframe > f || (pframe == f && pv >= v))) begin
            @(posedge clk);
            n++;
            if (n > 2000000) begin
                checks++;
                failures++;
                aborted = 1;
                $display("FAIL wait_frame%0d_line%0d: timed out at frame %0d line %0d", f, v, pframe, pv);
                return;
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vga_clk"}, 32'(vga_clk), 32'd0);
        check({tag, "_hs"}, 32'(vga_hs), 32'd1);
        check({tag, "_vs"}, 32'(vga_vs), 32'd1);
        check({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    endtask

    task automatic release_and_mark(output int unsigned t_pe);
        int n = 0;
        #1 resetn = 1'b1;
        t_pe = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vga_clk !== 1'b1 && n < 10);
        check("first_pix_en_seen", 32'(vga_clk), 32'd1);
        t_pe = cyc + 1;
    endtask

    initial begin
        int unsigned t_pe;
        logic [223:0] rnd;
        int n;
        resetn = 1'b0;
        board  = 200'd131071;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        release_and_mark(t_pe);

        wait_until(1, 300);
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        board = rnd[199:0];

        wait_until(2, 300);
        if (!aborted) begin
            check("hs_fall_count_ok", 32'(hs_fall.size() >= 2 && hs_rise.size() >= 1), 32'd1);
            check("vs_fall_count_ok", 32'(vs_fall.size() >= 2 && vs_rise.size() >= 1), 32'd1);
            if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
                check("hs_period", hs_fall[1] - hs_fall[0], 32'd1600);
                check("hs_low_width", hs_rise[0] - hs_fall[0], 32'd192);
                check("first_hs_delay", hs_fall[0] - t_pe, 32'd1312);
            end
            if (vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
                check("vs_period", vs_fall[1] - vs_fall[0], 32'd840000);
                check("vs_low_width", vs_rise[0] - vs_fall[0], 32'd3200);
            end
        end
        board = '1;

        wait_until(3, 200);
        board = '0;

        wait_until(4, 300);
        if (!aborted) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (vga_clk !== 1'b1 && n < 10);
            resetn = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_reset_outputs("mid");
            release_and_mark(t_pe);
            n = 0;
            while (hs_fall.size() == 0 && n < 3000) begin
                @(posedge clk);
                n++;
            end
            check("hs_fall_after_reset_seen", 32'(hs_fall.size() > 0), 32'd1);
            if (hs_fall.size() > 0) check("hs_delay_after_reset", hs_fall[0] - t_pe, 32'd1312);
            wait_until(100, 3);
        end

        @(negedge clk);
        check("pixel_compare_volume", 32'(pix_checks >= 1900000), 32'd1);
        check("point_samples_hit", 32'(point_hits), 32'd9);
        check("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tetris_vga_renderer.md
TETRIS_VGA_RENDERER -- requirements
Module: tetris_vga_renderer

Interface
REQ-001 Parameter CELL_PX, default 16: cell edge in pixels.
REQ-002 Parameter BOARD_X0, default 240: first visible pixel column of the board.
REQ-003 Parameter BOARD_Y0, default 80: first visible pixel line of the board.
REQ-004 Port clk, input, 1: 50 MHz system clock.
REQ-005 Port resetn, input, 1: synchronous, active-low reset.
REQ-006 Port board, input, 200: board state, 10x20 grid; bit index = row*10 + col; row 0 is the top row; 1 = filled.
REQ-007 Port vga_clk, output, 1: 25 MHz pixel clock to the DAC, equal to the registered pixel-enable toggle.
REQ-008 Port vga_hs, output, 1: horizontal sync, active low.
REQ-009 Port vga_vs, output, 1: vertical sync, active low.
REQ-010 Port vga_blank_n, output, 1: high inside the 640x480 active area.
REQ-011 Ports vga_r, vga_g and vga_b, outputs, 8 each: pixel colour.

Function
REQ-012 Pixel enable pix_en SHALL toggle every clk, so the pixel rate is clk/2; counters advance only when pix_en=1.
REQ-013 hcount SHALL count 0..799 and wrap to 0; vcount SHALL increment when hcount wraps and count 0..524, then wrap to 0.
REQ-014 Active area: hcount<640 and vcount<480.
REQ-015 vga_hs SHALL be low for hcount 656..751; vga_vs SHALL be low for vcount 490..491.
REQ-016 Frame buffer: board SHALL be copied into an internal 200-bit shadow register exactly once per frame, on the pix_en cycle where hcount=0 and vcount=480; rendering uses only the shadow, so a mid-frame change of board never tears.
REQ-017 Board region: BOARD_X0 <= hcount < BOARD_X0+10*CELL_PX and BOARD_Y0 <= vcount < BOARD_Y0+20*CELL_PX.
REQ-018 Cell address inside the region: col=(hcount-BOARD_X0)/CELL_PX and row=(vcount-BOARD_Y0)/CELL_PX; division is by shifts (CELL_PX a power of two), with no multiplier in the pixel path except the row*10 index.
REQ-019 Colour in the board region: a filled cell SHALL be R=00, G=FF, B=FF; an empty cell SHALL be 20,20,20. The outermost pixel row and column of each cell (local x or y = CELL_PX-1) SHALL be grid colour 40,40,40 regardless of fill.
REQ-020 Colour for the 4-pixel frame immediately surrounding the board region: 80,80,80.
REQ-021 Colour for all other active pixels: 00,00,00. Colour outside the active area: 00,00,00 with vga_blank_n=0.
REQ-022 Latency: vga_hs, vga_vs, vga_blank_n and colour SHALL all be registered and SHALL all correspond to the same (hcount,vcount), one pix_en step after the counter value, so they are mutually aligned.
REQ-023 Out-of-range board bits (none exist; index is at most 199) SHALL NOT be read.

Reset
REQ-024 While resetn=0 at a clk edge: hcount=0, vcount=0, pix_en=0, vga_clk=0, shadow=0.
REQ-025 While resetn=0 at a clk edge: vga_hs=1, vga_vs=1, vga_blank_n=0, colour=0.
REQ-026 A reset asserted mid-frame SHALL abandon the frame; the first pix_en after release starts at (0,0).
REQ-027 The shadow SHALL stay 0 (all cells empty) until the first capture at vcount=480.

Structure
REQ-028 Package tetris_pkg SHALL hold: BOARD_W=10 and BOARD_H=20; the VGA timing constants (H_ACTIVE 640, H_FP_END 656, H_SYNC_END 752, H_TOTAL 800, V_ACTIVE 480, V_SYNC_START 490, V_SYNC_END 492, V_TOTAL 525); and an rgb_t struct of three 8-bit fields.
REQ-029 Sub-module vga_timing SHALL own pix_en, hcount, vcount and the raw sync and active flags; tetris_vga_renderer adds the shadow, cell lookup and output registers.

Verification
REQ-030 Release reset, run 2 frames -> hsync period 1600 clk, low width 192 clk; vsync period 840000 clk, low width 3200 clk.
REQ-031 board=131071 (bits 0..16) -> frame 2: row 0 cols 0..9 cyan and row 1 cols 0..6 cyan; sample pixel (248,88) is 00,FF,FF, pixel (248,104) is 00,FF,FF, pixel (360,104) is 20,20,20.
REQ-032 board=all ones, then change to 0 at vcount=200 -> remainder of that frame still cyan; next frame all cells 20,20,20.
REQ-033 Pixel (255,80) (cell edge) -> 40,40,40; pixel (238,200) (frame) -> 80,80,80; pixel (10,10) -> 00,00,00.
REQ-034 Assert resetn=0 at vcount=300 for 3 clk -> outputs equal their reset values; after release, the first hsync falls 1312 clk after the first pix_en.
REQ-035 A scoreboard SHALL model the full frame and compare every active pixel's colour and vga_blank_n alignment against the model for a random board.
